// File: rtl/ifu_pkg.sv
// Shared types and default tuning constants for the instruction-fetch memory arbiter.
package ifu_pkg;

  localparam int unsigned DEF_TIMEOUT    = 16;
  localparam int unsigned DEF_STARVE_MAX = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } t_arb_state;

  typedef enum logic {
    DEMAND = 1'b0,
    PF     = 1'b1
  } t_arb_src;

endpackage

// File: rtl/ifu_mem_arb_if.sv
// Cache/prefetcher/memory signal bundle; master is the arbiter, slave is its environment.
interface ifu_mem_arb_if #(
  parameter int unsigned TAG_WIDTH  = 6,
  parameter int unsigned LINE_WIDTH = 32
);

  logic [TAG_WIDTH-1:0]  cache_reqTagIn;
  logic                  cache_reqTagValidIn;
  logic [TAG_WIDTH-1:0]  pf_reqTagIn;
  logic                  pf_reqTagValidIn;
  logic                  pf_reqAcceptOut;
  logic [TAG_WIDTH-1:0]  mem_reqTagOut;
  logic                  mem_reqValidOut;
  logic                  mem_reqReadyIn;
  logic [TAG_WIDTH-1:0]  mem_rspTagIn;
  logic [LINE_WIDTH-1:0] mem_rspInsLineIn;
  logic                  mem_rspInsLineValidIn;
  logic [TAG_WIDTH-1:0]  cache_rspTagOut;
  logic [LINE_WIDTH-1:0] cache_rspInsLineOut;
  logic                  cache_rspInsLineValidOut;
  logic                  busyOut;
  logic                  timeoutErrOut;

  modport master (
    input  cache_reqTagIn, cache_reqTagValidIn, pf_reqTagIn, pf_reqTagValidIn,
           mem_reqReadyIn, mem_rspTagIn, mem_rspInsLineIn, mem_rspInsLineValidIn,
    output pf_reqAcceptOut, mem_reqTagOut, mem_reqValidOut, cache_rspTagOut,
           cache_rspInsLineOut, cache_rspInsLineValidOut, busyOut, timeoutErrOut
  );

  modport slave (
    output cache_reqTagIn, cache_reqTagValidIn, pf_reqTagIn, pf_reqTagValidIn,
           mem_reqReadyIn, mem_rspTagIn, mem_rspInsLineIn, mem_rspInsLineValidIn,
    input  pf_reqAcceptOut, mem_reqTagOut, mem_reqValidOut, cache_rspTagOut,
           cache_rspInsLineOut, cache_rspInsLineValidOut, busyOut, timeoutErrOut
  );

endinterface

// File: rtl/ifu_arb_timeout_cnt.sv
// WAIT-state watchdog: counts enabled cycles and flags the TIMEOUT-th one.
module ifu_arb_timeout_cnt
  import ifu_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic Clock,
  input  logic Rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CNT_W-1:0] cntQ, cntD;

  assign expired = enable && (cntQ == CNT_W'(TIMEOUT - 1));

  always_comb begin
    cntD = cntQ;
    if (clear || expired) begin
      cntD = '0;
    end else if (enable) begin
      cntD = cntQ + 1'b1;
    end
  end

  always_ff @(posedge Clock) begin
    if (Rst) begin
      cntQ <= '0;
    end else begin
      cntQ <= cntD;
    end
  end

endmodule

// File: rtl/ifu_mem_arb.sv
// Single-outstanding arbiter between demand misses and prefetches toward instruction memory,
// with prefetch anti-starvation, duplicate squashing and timeout reissue.
module ifu_mem_arb
  import ifu_pkg::*;
#(
  parameter int unsigned TAG_WIDTH  = 6,
  parameter int unsigned LINE_WIDTH = 32,
  parameter int unsigned TIMEOUT    = DEF_TIMEOUT,
  parameter int unsigned STARVE_MAX = DEF_STARVE_MAX
) (
  input logic           Clock,
  input logic           Rst,
  ifu_mem_arb_if.master bus
);

  localparam int unsigned STARVE_W = $clog2(STARVE_MAX + 1);

  t_arb_state            stateQ, stateD;
  t_arb_src              srcQ;
  logic [TAG_WIDTH-1:0]  tagQ;
  logic [STARVE_W-1:0]   starveQ, starveD;
  logic                  timeoutErrQ;
  logic                  rspValidQ;
  logic [TAG_WIDTH-1:0]  rspTagQ;
  logic [LINE_WIDTH-1:0] rspLineQ;

  logic demValid, pfValid, pfSquash, starveFull;
  logic demGrant, pfGrant, rspHit, expired;

  assign demValid   = bus.cache_reqTagValidIn;
  assign pfValid    = bus.pf_reqTagValidIn;
  assign starveFull = (starveQ == STARVE_W'(STARVE_MAX));

  assign pfSquash = pfValid &&
                    (((stateQ != IDLE) && (bus.pf_reqTagIn == tagQ)) ||
                     (demValid && (bus.pf_reqTagIn == bus.cache_reqTagIn)));

  // No grant while a fill is being presented: the served demand is still high that cycle.
  assign demGrant = (stateQ == IDLE) && !rspValidQ && demValid &&
                    !(pfValid && !pfSquash && starveFull);
  assign pfGrant  = (stateQ == IDLE) && !rspValidQ && pfValid && !pfSquash &&
                    (!demValid || starveFull);

  assign rspHit = (stateQ == WAIT) && bus.mem_rspInsLineValidIn && (bus.mem_rspTagIn == tagQ);

  ifu_arb_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .Clock   (Clock),
    .Rst     (Rst),
    .clear   (stateQ != WAIT),
    .enable  (stateQ == WAIT),
    .expired (expired)
  );

  always_ff @(posedge Clock) begin
    if (Rst) begin
      stateQ <= IDLE;
    end else begin
      stateQ <= stateD;
    end
  end

  always_comb begin
    stateD = stateQ;
    unique case (stateQ)
      IDLE:    if (demGrant || pfGrant) stateD = ISSUE;
      ISSUE:   if (bus.mem_reqReadyIn) stateD = WAIT;
      WAIT: begin
        if (rspHit) begin
          stateD = IDLE;
        end else if (expired) begin
          stateD = ISSUE;
        end
      end
      default: stateD = IDLE;
    endcase
  end

  // Counter is only consulted in IDLE, so clearing it once the granted prefetch reaches ISSUE
  // is equivalent to clearing it at the grant itself.
  always_comb begin
    starveD = starveQ;
    if (pfSquash || ((stateQ == ISSUE) && (srcQ == PF))) begin
      starveD = '0;
    end else if (demGrant && pfValid && !starveFull) begin
      starveD = starveQ + 1'b1;
    end
  end

  always_ff @(posedge Clock) begin
    if (Rst) begin
      tagQ        <= '0;
      srcQ        <= DEMAND;
      starveQ     <= '0;
      timeoutErrQ <= 1'b0;
      rspValidQ   <= 1'b0;
      rspTagQ     <= '0;
      rspLineQ    <= '0;
    end else begin
      if (demGrant) begin
        tagQ <= bus.cache_reqTagIn;
        srcQ <= DEMAND;
      end else if (pfGrant) begin
        tagQ <= bus.pf_reqTagIn;
        srcQ <= PF;
      end
      starveQ <= starveD;
      if ((stateQ == WAIT) && expired && !rspHit) begin
        timeoutErrQ <= 1'b1;
      end
      rspValidQ <= rspHit;
      if (rspHit) begin
        rspTagQ  <= bus.mem_rspTagIn;
        rspLineQ <= bus.mem_rspInsLineIn;
      end
    end
  end

  always_comb begin
    bus.mem_reqValidOut          = (stateQ == ISSUE);
    bus.mem_reqTagOut            = (stateQ == ISSUE) ? tagQ : '0;
    bus.busyOut                  = (stateQ != IDLE);
    bus.pf_reqAcceptOut          = !Rst && (pfSquash || pfGrant);
    bus.cache_rspInsLineValidOut = rspValidQ;
    bus.cache_rspTagOut          = rspTagQ;
    bus.cache_rspInsLineOut      = rspLineQ;
    bus.timeoutErrOut            = timeoutErrQ;
  end

endmodule

// File: tb/tb_ifu_mem_arb.sv
// Directed bench for ifu_mem_arb: hand-computed expectations checked with immediate assertions.
module tb_ifu_mem_arb;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  ifu_mem_arb_if #(.TAG_WIDTH(6), .LINE_WIDTH(32)) bus ();

  ifu_mem_arb #(
    .TAG_WIDTH  (6),
    .LINE_WIDTH (32),
    .TIMEOUT    (16),
    .STARVE_MAX (4)
  ) dut (
    .Clock (clk),
    .Rst   (rst),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic setRsp(input logic [5:0] tag, input logic [31:0] line);
    bus.mem_rspTagIn          = tag;
    bus.mem_rspInsLineIn      = line;
    bus.mem_rspInsLineValidIn = 1'b1;
  endtask

  task automatic clrRsp();
    bus.mem_rspInsLineValidIn = 1'b0;
    bus.mem_rspTagIn          = '0;
    bus.mem_rspInsLineIn      = '0;
  endtask

  initial begin
    bus.cache_reqTagIn      = '0;
    bus.cache_reqTagValidIn = 1'b0;
    bus.pf_reqTagIn         = '0;
    bus.pf_reqTagValidIn    = 1'b0;
    bus.mem_reqReadyIn      = 1'b0;
    clrRsp();
    tick();
    tick();

    chk("rst_busy", 32'(bus.busyOut), 0);
    chk("rst_memValid", 32'(bus.mem_reqValidOut), 0);
    chk("rst_memTag", 32'(bus.mem_reqTagOut), 0);
    chk("rst_fillValid", 32'(bus.cache_rspInsLineValidOut), 0);
    chk("rst_fillTag", 32'(bus.cache_rspTagOut), 0);
    chk("rst_fillLine", bus.cache_rspInsLineOut, 0);
    chk("rst_timeoutErr", 32'(bus.timeoutErrOut), 0);
    chk("rst_pfAccept", 32'(bus.pf_reqAcceptOut), 0);
    rst = 1'b0;

    // Basic demand miss
    bus.cache_reqTagIn      = 6'h01;
    bus.cache_reqTagValidIn = 1'b1;
    bus.mem_reqReadyIn      = 1'b1;
    #1;
    chk("t1_idle_noreq", 32'(bus.mem_reqValidOut), 0);
    tick();
    chk("t1_issue_valid", 32'(bus.mem_reqValidOut), 1);
    chk("t1_issue_tag", 32'(bus.mem_reqTagOut), 32'h01);
    chk("t1_busy", 32'(bus.busyOut), 1);
    tick();
    chk("t1_wait_novalid", 32'(bus.mem_reqValidOut), 0);
    tick();
    setRsp(6'h01, 32'hDEADBEEF);
    tick();
    chk("t1_fill_valid", 32'(bus.cache_rspInsLineValidOut), 1);
    chk("t1_fill_tag", 32'(bus.cache_rspTagOut), 32'h01);
    chk("t1_fill_line", bus.cache_rspInsLineOut, 32'hDEADBEEF);
    chk("t1_busy_drop", 32'(bus.busyOut), 0);
    clrRsp();
    bus.cache_reqTagValidIn = 1'b0;
    tick();
    chk("t1_fill_once", 32'(bus.cache_rspInsLineValidOut), 0);
    chk("t1_no_rereq", 32'(bus.mem_reqValidOut), 0);

    // Same-cycle demand and prefetch: demand first
    bus.cache_reqTagIn      = 6'h02;
    bus.cache_reqTagValidIn = 1'b1;
    bus.pf_reqTagIn         = 6'h03;
    bus.pf_reqTagValidIn    = 1'b1;
    #1;
    chk("t2_tie_noaccept", 32'(bus.pf_reqAcceptOut), 0);
    tick();
    chk("t2_issue_demand", 32'(bus.mem_reqTagOut), 32'h02);
    chk("t2_issue_noaccept", 32'(bus.pf_reqAcceptOut), 0);
    tick();
    setRsp(6'h02, 32'h22222222);
    tick();
    chk("t2_fill_demand", 32'(bus.cache_rspTagOut), 32'h02);
    clrRsp();
    bus.cache_reqTagValidIn = 1'b0;
    #1;
    chk("t2_fill_cycle_noaccept", 32'(bus.pf_reqAcceptOut), 0);
    tick();
    chk("t2_pf_accept", 32'(bus.pf_reqAcceptOut), 1);
    tick();
    chk("t2_issue_pf", 32'(bus.mem_reqTagOut), 32'h03);
    bus.pf_reqTagValidIn = 1'b0;
    #1;
    chk("t2_accept_once", 32'(bus.pf_reqAcceptOut), 0);
    tick();
    setRsp(6'h03, 32'h33333333);
    tick();
    chk("t2_fill_pf", 32'(bus.cache_rspTagOut), 32'h03);
    clrRsp();
    tick();

    // Four demand grants while prefetch waits, then the prefetch wins
    bus.pf_reqTagIn         = 6'h3F;
    bus.pf_reqTagValidIn    = 1'b1;
    bus.cache_reqTagValidIn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.cache_reqTagIn = 6'(16 + k);
      #1;
      chk("t3_dem_noaccept", 32'(bus.pf_reqAcceptOut), 0);
      tick();
      chk("t3_dem_issue", 32'(bus.mem_reqTagOut), 32'(16 + k));
      tick();
      setRsp(6'(16 + k), 32'(k));
      tick();
      chk("t3_dem_fill", 32'(bus.cache_rspTagOut), 32'(16 + k));
      clrRsp();
      tick();
    end
    bus.cache_reqTagIn = 6'h14;
    #1;
    chk("t3_pf_wins", 32'(bus.pf_reqAcceptOut), 1);
    tick();
    chk("t3_issue_pf", 32'(bus.mem_reqTagOut), 32'h3F);
    bus.pf_reqTagValidIn    = 1'b0;
    bus.cache_reqTagValidIn = 1'b0;
    tick();
    setRsp(6'h3F, 32'h3F3F3F3F);
    tick();
    chk("t3_fill_pf", 32'(bus.cache_rspTagOut), 32'h3F);
    clrRsp();
    tick();

    // Demand merged into outstanding prefetch
    bus.pf_reqTagIn      = 6'h05;
    bus.pf_reqTagValidIn = 1'b1;
    #1;
    chk("t4_pf_accept", 32'(bus.pf_reqAcceptOut), 1);
    tick();
    chk("t4_issue_pf", 32'(bus.mem_reqTagOut), 32'h05);
    bus.pf_reqTagValidIn = 1'b0;
    tick();
    bus.cache_reqTagIn      = 6'h05;
    bus.cache_reqTagValidIn = 1'b1;
    #1;
    chk("t4_merge_noreq", 32'(bus.mem_reqValidOut), 0);
    tick();
    chk("t4_merge_noreq2", 32'(bus.mem_reqValidOut), 0);
    chk("t4_merge_busy", 32'(bus.busyOut), 1);
    setRsp(6'h05, 32'h55555555);
    tick();
    chk("t4_fill_valid", 32'(bus.cache_rspInsLineValidOut), 1);
    chk("t4_fill_tag", 32'(bus.cache_rspTagOut), 32'h05);
    chk("t4_fill_line", bus.cache_rspInsLineOut, 32'h55555555);
    clrRsp();
    bus.cache_reqTagValidIn = 1'b0;
    tick();
    chk("t4_one_fill", 32'(bus.cache_rspInsLineValidOut), 0);
    chk("t4_no_second_req", 32'(bus.mem_reqValidOut), 0);
    chk("t4_idle", 32'(bus.busyOut), 0);

    // Wrong-tag response dropped, then timeout reissue
    bus.cache_reqTagIn      = 6'h06;
    bus.cache_reqTagValidIn = 1'b1;
    tick();
    tick();
    setRsp(6'h07, 32'h77777777);
    tick();
    chk("t5_wrong_tag_dropped", 32'(bus.cache_rspInsLineValidOut), 0);
    clrRsp();
    repeat (14) tick();
    chk("t5_wait16_noreq", 32'(bus.mem_reqValidOut), 0);
    chk("t5_wait16_noerr", 32'(bus.timeoutErrOut), 0);
    tick();
    chk("t5_reissue_valid", 32'(bus.mem_reqValidOut), 1);
    chk("t5_reissue_tag", 32'(bus.mem_reqTagOut), 32'h06);
    chk("t5_timeout_err", 32'(bus.timeoutErrOut), 1);
    tick();
    setRsp(6'h06, 32'h66666666);
    tick();
    chk("t5_fill_tag", 32'(bus.cache_rspTagOut), 32'h06);
    chk("t5_err_sticky", 32'(bus.timeoutErrOut), 1);
    clrRsp();
    bus.cache_reqTagValidIn = 1'b0;
    tick();

    // Prefetch equal to the current demand tag is squashed
    bus.cache_reqTagIn      = 6'h09;
    bus.cache_reqTagValidIn = 1'b1;
    bus.pf_reqTagIn         = 6'h09;
    bus.pf_reqTagValidIn    = 1'b1;
    #1;
    chk("t6_squash_accept", 32'(bus.pf_reqAcceptOut), 1);
    tick();
    chk("t6_issue_demand", 32'(bus.mem_reqTagOut), 32'h09);
    bus.pf_reqTagValidIn = 1'b0;
    tick();
    setRsp(6'h09, 32'h99999999);
    tick();
    chk("t6_fill", 32'(bus.cache_rspTagOut), 32'h09);
    clrRsp();
    bus.cache_reqTagValidIn = 1'b0;
    tick();
    chk("t6_no_pf_req", 32'(bus.mem_reqValidOut), 0);

    // Reset while waiting abandons the request
    bus.cache_reqTagIn      = 6'h0A;
    bus.cache_reqTagValidIn = 1'b1;
    tick();
    tick();
    chk("t7_wait_busy", 32'(bus.busyOut), 1);
    rst                     = 1'b1;
    bus.cache_reqTagValidIn = 1'b0;
    tick();
    chk("t7_rst_busy", 32'(bus.busyOut), 0);
    chk("t7_rst_memValid", 32'(bus.mem_reqValidOut), 0);
    chk("t7_rst_memTag", 32'(bus.mem_reqTagOut), 0);
    chk("t7_rst_fill", 32'(bus.cache_rspInsLineValidOut), 0);
    chk("t7_rst_err", 32'(bus.timeoutErrOut), 0);
    chk("t7_rst_accept", 32'(bus.pf_reqAcceptOut), 0);
    rst = 1'b0;
    setRsp(6'h0A, 32'hAAAAAAAA);
    tick();
    chk("t7_late_rsp_dropped", 32'(bus.cache_rspInsLineValidOut), 0);
    chk("t7_idle", 32'(bus.busyOut), 0);
    chk("t7_noreq", 32'(bus.mem_reqValidOut), 0);
    clrRsp();
    tick();
    chk("t7_still_nofill", 32'(bus.cache_rspInsLineValidOut), 0);
    chk("t7_fill_tag_clear", 32'(bus.cache_rspTagOut), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ifu_mem_arb.md
IFU_MEM_ARB -- requirements
Module: ifu_mem_arb

Interface
- REQ-001 Parameter TAG_WIDTH, default 6: width of the line tag carried on all tag ports.
- REQ-002 Parameter LINE_WIDTH, default 32: width of an instruction line.
- REQ-003 Parameter TIMEOUT, default 16: cycles in WAIT before the request is reissued.
- REQ-004 Parameter STARVE_MAX, default 4: consecutive demand grants allowed while a prefetch is pending.
- REQ-005 Clock  input  1  single clock, rising edge.
- REQ-006 Rst  input  1  reset, synchronous, active-high.
- REQ-007 cache_reqTagIn  input  TAG_WIDTH  demand-miss tag from the cache.
- REQ-008 cache_reqTagValidIn  input  1  demand-miss valid, level, held until the fill is returned.
- REQ-009 pf_reqTagIn  input  TAG_WIDTH  prefetch tag.
- REQ-010 pf_reqTagValidIn  input  1  prefetch valid, held until pf_reqAcceptOut.
- REQ-011 pf_reqAcceptOut  output  1  one-cycle pulse: prefetch consumed (granted or squashed).
- REQ-012 mem_reqTagOut  output  TAG_WIDTH  tag to memory.
- REQ-013 mem_reqValidOut  output  1  memory request valid.
- REQ-014 mem_reqReadyIn  input  1  memory accepts the request when it is high together with valid.
- REQ-015 mem_rspTagIn  input  TAG_WIDTH  returned tag.
- REQ-016 mem_rspInsLineIn  input  LINE_WIDTH  returned line.
- REQ-017 mem_rspInsLineValidIn  input  1  returned line valid.
- REQ-018 cache_rspTagOut / cache_rspInsLineOut / cache_rspInsLineValidOut  output  TAG_WIDTH / LINE_WIDTH / 1  fill to the cache, registered.
- REQ-019 busyOut  output  1  high whenever the state is not IDLE.
- REQ-020 timeoutErrOut  output  1  sticky; set on any reissue.

Function
- REQ-021 The FSM SHALL have states IDLE, ISSUE and WAIT, with one outstanding memory request at most.
- REQ-022 In IDLE with demand valid, the block SHALL latch the demand tag with src=DEMAND and go to ISSUE; demand SHALL win a same-cycle tie against prefetch.
- REQ-023 In IDLE with only prefetch valid, or with both valid and the starve counter equal to STARVE_MAX, the block SHALL latch the prefetch tag with src=PF, pulse pf_reqAcceptOut and go to ISSUE.
- REQ-024 A prefetch whose tag equals the latched outstanding tag or the current demand tag SHALL be squashed: pf_reqAcceptOut pulses and no memory request is made for it.
- REQ-025 The starve counter SHALL increment on each demand grant while prefetch is valid, saturate at STARVE_MAX, and clear on a prefetch grant or squash.
- REQ-026 In ISSUE, mem_reqValidOut SHALL be 1 and mem_reqTagOut SHALL equal the latched tag; on mem_reqReadyIn the block SHALL go to WAIT.
- REQ-027 First mem_reqValidOut SHALL occur exactly 1 cycle after the granting IDLE cycle.
- REQ-028 In WAIT, a response with matching tag SHALL drive cache_rsp* (valid=1) on the next cycle for one cycle, regardless of src, and the FSM SHALL return to IDLE.
- REQ-029 A response with a non-matching tag, or any response arriving outside WAIT, SHALL be dropped.
- REQ-030 A demand arriving in WAIT with tag equal to the outstanding PF tag SHALL be merged (no new request); the fill serves it.
- REQ-031 The WAIT cycle counter SHALL reach TIMEOUT, then move the FSM to ISSUE with the same tag, set timeoutErrOut and clear the counter.
- REQ-032 A response and a timeout in the same cycle SHALL be treated as a response.

Reset
- REQ-033 On Rst, the block SHALL enter IDLE and clear all outputs, counters, latched tag, src and timeoutErrOut to 0.
- REQ-034 Reset mid-operation SHALL abandon the outstanding request; a later response to it SHALL be dropped per REQ-029.

Structure
- REQ-035 ifu_pkg SHALL hold t_arb_state (IDLE/ISSUE/WAIT), t_arb_src (DEMAND/PF) and the default TIMEOUT and STARVE_MAX constants.
- REQ-036 The WAIT timer SHALL be one sub-module, ifu_arb_timeout_cnt, with clear, enable and expired ports.

Verification
- REQ-037 Demand 0x01 in IDLE, ready=1, response 0x01/0xDEADBEEF 3 cycles later -> mem_reqValidOut at +1; cache fill 0x01/0xDEADBEEF with valid for 1 cycle; busyOut drops.
- REQ-038 Same-cycle demand 0x02 and PF 0x03 -> 0x02 is issued first and no accept pulse occurs; after that fill, PF 0x03 is issued and pf_reqAcceptOut pulses once.
- REQ-039 Demand held continuously for 4 tags while PF 0x3F is pending -> the 5th grant goes to PF 0x3F.
- REQ-040 PF 0x05 outstanding, then demand 0x05 arrives -> no second memory request; one fill 0x05 is sent to the cache.
- REQ-041 No response for 16 WAIT cycles -> the same tag is reissued and timeoutErrOut=1; a wrong-tag response 0x07 for outstanding 0x06 produces no fill.
- REQ-042 Rst asserted in WAIT, then a response arrives -> all outputs are 0 and no fill occurs.
